// File: rtl/vga_timing_if.sv
// Bundle between the VGA timing generator and its consumers.
// master drives x/y, syncs, blank, frame pulse/count; slave drives run.
interface vga_timing_if;
    logic        run;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pix_tick;
    logic        hsync_n;
    logic        vsync_n;
    logic        blank_n;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        input  run,
        output x,
        output y,
        output pix_tick,
        output hsync_n,
        output vsync_n,
        output blank_n,
        output frame_start,
        output frame_count
    );

    modport slave (
        output run,
        input  x,
        input  y,
        input  pix_tick,
        input  hsync_n,
        input  vsync_n,
        input  blank_n,
        input  frame_start,
        input  frame_count
    );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-enable divider, x/y counters,
// decoded sync/blank, frame pulse and frame counter.
// Ports: clk, rst (sync, active-high), bus (vga_timing_if.master).
module vga_timing #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_if.master  bus
);

    // 11-bit compare constants keep parameter sums from overflowing
    localparam logic [10:0] H_TOTAL =
        11'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [10:0] V_TOTAL =
        11'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_W = 11'(V_SYNC);
    localparam logic [10:0] H_VIS_LO = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_VIS_HI = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_VIS_LO = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_VIS_HI = 11'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] H_LAST   = H_TOTAL - 11'd1;
    localparam logic [10:0] V_LAST   = V_TOTAL - 11'd1;

    logic        tick_q;
    logic [10:0] x_q;
    logic [10:0] y_q;
    logic [15:0] frame_cnt;

    logic adv;
    logic x_last;
    logic y_last;

    // one pixel step per pixel-clock enable, only while running
    assign adv    = bus.run & tick_q;
    assign x_last = (x_q == H_LAST);
    assign y_last = (y_q == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else if (bus.run) begin
            tick_q <= ~tick_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= 11'd0;
        end else if (adv) begin
            x_q <= x_last ? 11'd0 : x_q + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= 11'd0;
        end else if (adv && x_last) begin
            y_q <= y_last ? 11'd0 : y_q + 11'd1;
        end
    end

    // counts frames completed: bumps on the edge x and y both wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (adv && x_last && y_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign bus.x           = x_q[9:0];
    assign bus.y           = y_q[9:0];
    assign bus.pix_tick    = tick_q;
    assign bus.frame_count = frame_cnt;

    // decoded straight from the registered counters, no extra latency
    assign bus.hsync_n = (x_q >= H_SYNC_W);
    assign bus.vsync_n = (y_q >= V_SYNC_W);
    assign bus.blank_n = (x_q >= H_VIS_LO) && (x_q < H_VIS_HI) &&
                         (y_q >= V_VIS_LO) && (y_q < V_VIS_HI);

    // second clk of raster position (0,0): the pixel-enable cycle
    assign bus.frame_start = adv && (x_q == 11'd0) && (y_q == 11'd0);

endmodule

// File: tb/tb_vga_timing.sv
// Directed self-checking bench for vga_timing on a reduced raster.
// H: 4 sync, 3 bp, 8 active, 2 fp (17); V: 2, 2, 4, 1 (9).
module tb_vga_timing;

    localparam int HS = 4, HB = 3, HA = 8, HF = 2;
    localparam int VS = 2, VB = 2, VA = 4, VF = 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vga_timing_if bus ();

    vga_timing #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n, hl, vl, bh, fs, wraps, bad, rises;
        int rx, ry, fx;
        logic pb;
        logic [9:0] px, hx, hy;
        logic ht;
        logic [15:0] hf, fc0;

        rst = 1'b1;
        bus.run = 1'b0;
        repeat (3) step();
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_tick", bus.pix_tick, 0);
        chk("rst_fc", bus.frame_count, 0);
        chk("rst_fs", bus.frame_start, 0);
        chk("rst_hs", bus.hsync_n, 0);
        chk("rst_vs", bus.vsync_n, 0);
        chk("rst_blank", bus.blank_n, 0);

        rst = 1'b0;
        bus.run = 1'b1;
        step();
        chk("first_tick", bus.pix_tick, 1);
        chk("first_x", bus.x, 0);
        chk("first_fs", bus.frame_start, 1);
        step();
        chk("second_tick", bus.pix_tick, 0);
        chk("second_x", bus.x, 1);
        chk("second_fs", bus.frame_start, 0);

        // one full line period: 17 pixels * 2 clks
        hl = 0; bad = 0; wraps = 0; px = bus.x;
        for (int i = 0; i < 34; i++) begin
            step();
            if (!bus.hsync_n) hl++;
            if (bus.x == 0 && px == 10'd16) wraps++;
            if (bus.x != px && 32'(bus.x) != (32'(px) + 1) % 17) bad++;
            px = bus.x;
        end
        chk("line_hsync_low", hl, 8);
        chk("line_wraps", wraps, 1);
        chk("line_x_seq", bad, 0);

        n = 0;
        while (!bus.frame_start && n < 400) begin
            step();
            n++;
        end
        chk("fs_found", bus.frame_start, 1);

        fc0 = bus.frame_count;
        n = 0; hl = 0; vl = 0; bh = 0; fs = 0; rises = 0;
        rx = -1; ry = -1; fx = -1;
        pb = bus.blank_n;
        do begin
            step();
            n++;
            if (!bus.hsync_n) hl++;
            if (!bus.vsync_n) vl++;
            if (bus.blank_n) bh++;
            if (bus.frame_start) fs++;
            if (bus.blank_n && !pb) begin
                rises++;
                if (rx < 0) begin
                    rx = int'(bus.x);
                    ry = int'(bus.y);
                end
            end
            if (!bus.blank_n && pb && fx < 0) fx = int'(bus.x);
            pb = bus.blank_n;
        end while (!bus.frame_start && n < 1000);
        chk("frame_period", n, 306);
        chk("frame_fs_cnt", fs, 1);
        chk("frame_vsync_low", vl, 68);
        chk("frame_hsync_low", hl, 72);
        chk("frame_blank_hi", bh, 64);
        chk("blank_lines", rises, 4);
        chk("blank_rise_x", rx, 7);
        chk("blank_rise_y", ry, 4);
        chk("blank_fall_x", fx, 15);
        chk("frame_cnt_inc", bus.frame_count, fc0 + 16'd1);

        n = 0;
        while (bus.x != 10'd5 && n < 40) begin
            step();
            n++;
        end
        chk("frz_found", bus.x, 5);
        bus.run = 1'b0;
        hx = bus.x; hy = bus.y; ht = bus.pix_tick; hf = bus.frame_count;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.x != hx || bus.y != hy) bad++;
            if (bus.pix_tick != ht || bus.frame_count != hf) bad++;
            if (bus.frame_start) bad++;
        end
        chk("frz_hold", bad, 0);
        bus.run = 1'b1;
        step();
        step();
        chk("frz_resume_x", bus.x, 6);

        n = 0;
        while (!(bus.y == 10'd5 && bus.x == 10'd8) && n < 400) begin
            step();
            n++;
        end
        chk("mid_found", (bus.y == 10'd5 && bus.x == 10'd8), 1);
        rst = 1'b1;
        repeat (3) step();
        chk("mid_x", bus.x, 0);
        chk("mid_y", bus.y, 0);
        chk("mid_fc", bus.frame_count, 0);
        chk("mid_tick", bus.pix_tick, 0);
        chk("mid_blank", bus.blank_n, 0);
        rst = 1'b0;

        n = 0;
        while (bus.y != 10'd3 && n < 400) begin
            step();
            n++;
        end
        chk("wrap_found", bus.y, 3);
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        chk("wrap_pre", bus.frame_count, 16'hFFFF);
        n = 0;
        while (bus.frame_count == 16'hFFFF && n < 400) begin
            step();
            n++;
        end
        chk("wrap_fc", bus.frame_count, 0);
        chk("wrap_x", bus.x, 0);
        chk("wrap_y", bus.y, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
